mem_port_arbiter: RTL and testbench

- Shares the single-port data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined CPU.
- Grants one requester per transaction and drives the memory port.
- Returns read data to the owning requester after the memory's fixed read latency.
- Produces per-stage stall signals for the pipeline control.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Handshake and memory-port bundle between the IF/MEM pipeline stages, the
// arbiter and the single-port data memory.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr_in;
    logic [DATA_W-1:0] mem_wdata_in;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata_out;

    logic              stall_if;
    logic              stall_mem;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr_in, mem_wdata_in, ram_rdata,
        output if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata_out,
        output stall_if, stall_mem, ram_en, ram_we, ram_addr, ram_wdata
    );

    // Pipeline stages plus memory side
    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr_in, mem_wdata_in, ram_rdata,
        input  if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata_out,
        input  stall_if, stall_mem, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data memory between instruction fetch and the
// MEM stage, tracks the outstanding read and returns its data to the owner.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned MAX_CONSEC = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus_io
);
    localparam int unsigned LAT_W  = 3;
    localparam int unsigned CONS_W = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [CONS_W-1:0]   consec_q, consec_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

    logic done_c;
    logic can_gnt_c;
    logic if_win_c;
    logic mem_win_c;
    logic if_rv_c;
    logic mem_rv_c;

    // Completion cycle of the outstanding read; also the only RD_WAIT grant slot.
    assign done_c    = (state_q == RD_WAIT) && (lat_q == LAT_W'(RD_LAT));
    assign can_gnt_c = !reset && ((state_q == IDLE) || done_c);

    // MEM has priority until it has starved a waiting fetch MAX_CONSEC times.
    assign if_win_c  = can_gnt_c && bus_io.if_req &&
                       (!bus_io.mem_req || (consec_q == CONS_W'(MAX_CONSEC)));
    assign mem_win_c = can_gnt_c && bus_io.mem_req && !if_win_c;

    assign if_rv_c   = !reset && done_c && (owner_q == OWN_IF);
    assign mem_rv_c  = !reset && done_c && (owner_q == OWN_MEM);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_d       = lat_q;
        consec_d    = consec_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        if (state_q == RD_WAIT) begin
            if (done_c) begin
                state_d = IDLE;
                owner_d = OWN_NONE;
                lat_d   = '0;
            end else begin
                lat_d = lat_q + LAT_W'(1);
            end
        end

        // A new read (possibly on the completion cycle) overrides the return to IDLE.
        if (if_win_c) begin
            state_d = RD_WAIT;
            owner_d = OWN_IF;
            lat_d   = LAT_W'(1);
        end else if (mem_win_c && !bus_io.mem_we) begin
            state_d = RD_WAIT;
            owner_d = OWN_MEM;
            lat_d   = LAT_W'(1);
        end

        if (!bus_io.if_req || if_win_c) begin
            consec_d = '0;
        end else if (mem_win_c && (consec_q != CONS_W'(MAX_CONSEC))) begin
            consec_d = consec_q + CONS_W'(1);
        end

        if (if_rv_c) begin
            if_rdata_d = bus_io.ram_rdata;
        end
        if (mem_rv_c) begin
            mem_rdata_d = bus_io.ram_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            lat_q       <= '0;
            consec_q    <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lat_q       <= lat_d;
            consec_q    <= consec_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus_io.if_gnt    = if_win_c;
    assign bus_io.mem_gnt   = mem_win_c;
    assign bus_io.if_rvalid  = if_rv_c;
    assign bus_io.mem_rvalid = mem_rv_c;

    // Read data is live on the completion cycle and held afterwards.
    assign bus_io.if_rdata      = if_rv_c  ? bus_io.ram_rdata : if_rdata_q;
    assign bus_io.mem_rdata_out = mem_rv_c ? bus_io.ram_rdata : mem_rdata_q;

    assign bus_io.ram_en    = if_win_c || mem_win_c;
    assign bus_io.ram_we    = mem_win_c && bus_io.mem_we;
    assign bus_io.ram_addr  = if_win_c  ? bus_io.if_addr :
                              mem_win_c ? bus_io.mem_addr_in : '0;
    assign bus_io.ram_wdata = mem_win_c ? bus_io.mem_wdata_in : '0;

    assign bus_io.stall_if  = !reset &&
        ((bus_io.if_req && !if_win_c) ||
         ((owner_q == OWN_IF) && (state_q == RD_WAIT) && !if_rv_c));
    assign bus_io.stall_mem = !reset &&
        ((bus_io.mem_req && !mem_win_c) ||
         ((owner_q == OWN_MEM) && (state_q == RD_WAIT) && !mem_rv_c));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with single-cycle read
// latency, one with three-cycle latency, each backed by a small memory model.
module tb_mem_port_arbiter;
    logic clk;
    logic reset;

    int unsigned n_vec;
    int unsigned n_err;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .MAX_CONSEC(4)) u_dut1 (
        .clk    (clk),
        .reset  (reset),
        .bus_io (b1.slave)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .MAX_CONSEC(4)) u_dut3 (
        .clk    (clk),
        .reset  (reset),
        .bus_io (b3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: word at address a reads back as DEAD_BEEF + a - 0x10.
    function automatic logic [31:0] data_of(input logic [31:0] a);
        return 32'hDEAD_BEEF + a - 32'h10;
    endfunction

    logic [31:0] pipe1;
    logic [31:0] pipe3 [3];

    always @(posedge clk) begin
        pipe1    <= (b1.ram_en && !b1.ram_we) ? data_of(b1.ram_addr) : 32'h0;
        pipe3[0] <= (b3.ram_en && !b3.ram_we) ? data_of(b3.ram_addr) : 32'h0;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    assign b1.ram_rdata = pipe1;
    assign b3.ram_rdata = pipe3[2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        b1.if_req = 1'b0; b1.if_addr = '0; b1.mem_req = 1'b0; b1.mem_we = 1'b0;
        b1.mem_addr_in = '0; b1.mem_wdata_in = '0;
        b3.if_req = 1'b0; b3.if_addr = '0; b3.mem_req = 1'b0; b3.mem_we = 1'b0;
        b3.mem_addr_in = '0; b3.mem_wdata_in = '0;

        // Outputs stay quiet under reset even with a pending fetch
        b1.if_req = 1'b1; b1.if_addr = 32'h10;
        step();
        @(negedge clk);
        check("rst_if_gnt",   32'(b1.if_gnt),   32'd0);
        check("rst_ram_en",   32'(b1.ram_en),   32'd0);
        check("rst_ram_addr", b1.ram_addr,      32'h0);
        check("rst_stall_if", 32'(b1.stall_if), 32'd0);
        check("rst_if_rdata", b1.if_rdata,      32'h0);
        step();

        // Fetch granted on the cycle reset releases, data one cycle later
        reset = 1'b0;
        @(negedge clk);
        check("t1_if_gnt",   32'(b1.if_gnt),   32'd1);
        check("t1_ram_en",   32'(b1.ram_en),   32'd1);
        check("t1_ram_addr", b1.ram_addr,      32'h10);
        check("t1_stall_if", 32'(b1.stall_if), 32'd0);
        step();
        b1.if_req = 1'b0;
        @(negedge clk);
        check("t1_if_rvalid", 32'(b1.if_rvalid), 32'd1);
        check("t1_if_rdata",  b1.if_rdata,       32'hDEAD_BEEF);
        check("t1_ram_en_c1", 32'(b1.ram_en),    32'd0);
        step();
        @(negedge clk);
        check("t1_rvalid_c2", 32'(b1.if_rvalid), 32'd0);
        check("t1_rdata_hold", b1.if_rdata,      32'hDEAD_BEEF);
        step();

        // Simultaneous fetch and load: MEM first, IF on MEM's completion cycle
        b1.if_req = 1'b1; b1.if_addr = 32'h80;
        b1.mem_req = 1'b1; b1.mem_we = 1'b0; b1.mem_addr_in = 32'h40;
        @(negedge clk);
        check("t2_mem_gnt",   32'(b1.mem_gnt),   32'd1);
        check("t2_if_gnt",    32'(b1.if_gnt),    32'd0);
        check("t2_ram_addr",  b1.ram_addr,       32'h40);
        check("t2_stall_if",  32'(b1.stall_if),  32'd1);
        check("t2_stall_mem", 32'(b1.stall_mem), 32'd0);
        step();
        b1.mem_req = 1'b0;
        @(negedge clk);
        check("t2_mem_rvalid", 32'(b1.mem_rvalid), 32'd1);
        check("t2_mem_rdata",  b1.mem_rdata_out,   32'hDEAD_BF1F);
        check("t2_if_gnt_c1",  32'(b1.if_gnt),     32'd1);
        check("t2_ram_addr_c1", b1.ram_addr,       32'h80);
        step();
        b1.if_req = 1'b0;
        @(negedge clk);
        check("t2_if_rvalid",  32'(b1.if_rvalid),  32'd1);
        check("t2_if_rdata",   b1.if_rdata,        32'hDEAD_BF5F);
        check("t2_mem_rv_c2",  32'(b1.mem_rvalid), 32'd0);
        step();

        // Store stream vs waiting fetch: four MEM grants, then IF
        b1.mem_req = 1'b1; b1.mem_we = 1'b1; b1.mem_addr_in = 32'h100; b1.mem_wdata_in = 32'h1234;
        b1.if_req = 1'b1; b1.if_addr = 32'h20;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t3_mem_gnt%0d", k),  32'(b1.mem_gnt),  32'd1);
            check($sformatf("t3_if_gnt%0d", k),   32'(b1.if_gnt),   32'd0);
            check($sformatf("t3_ram_we%0d", k),   32'(b1.ram_we),   32'd1);
            check($sformatf("t3_wdata%0d", k),    b1.ram_wdata,     32'h1234);
            check($sformatf("t3_addr%0d", k),     b1.ram_addr,      32'h100);
            check($sformatf("t3_stall_if%0d", k), 32'(b1.stall_if), 32'd1);
            step();
        end
        @(negedge clk);
        check("t3_if_gnt4",    32'(b1.if_gnt),    32'd1);
        check("t3_mem_gnt4",   32'(b1.mem_gnt),   32'd0);
        check("t3_ram_we4",    32'(b1.ram_we),    32'd0);
        check("t3_wdata4",     b1.ram_wdata,      32'h0);
        check("t3_addr4",      b1.ram_addr,       32'h20);
        check("t3_stall_mem4", 32'(b1.stall_mem), 32'd1);
        step();
        @(negedge clk);
        check("t3_if_rvalid5", 32'(b1.if_rvalid), 32'd1);
        check("t3_if_rdata5",  b1.if_rdata,       32'hDEAD_BEFF);
        check("t3_mem_gnt5",   32'(b1.mem_gnt),   32'd1);
        check("t3_ram_we5",    32'(b1.ram_we),    32'd1);
        step();
        b1.mem_req = 1'b0; b1.mem_we = 1'b0; b1.if_req = 1'b0;
        @(negedge clk);
        check("t3_idle_en", 32'(b1.ram_en), 32'd0);
        step();

        // Back-to-back fetches with three-cycle latency
        b3.if_req = 1'b1; b3.if_addr = 32'h0;
        @(negedge clk);
        check("t4_gnt0",  32'(b3.if_gnt), 32'd1);
        check("t4_addr0", b3.ram_addr,    32'h0);
        step();
        b3.if_addr = 32'h4;
        for (int f = 0; f < 3; f++) begin
            for (int w = 0; w < 2; w++) begin
                @(negedge clk);
                check($sformatf("t4_en_f%0d_w%0d", f, w),     32'(b3.ram_en),    32'd0);
                check($sformatf("t4_rv_f%0d_w%0d", f, w),     32'(b3.if_rvalid), 32'd0);
                check($sformatf("t4_stall_f%0d_w%0d", f, w),  32'(b3.stall_if),  32'd1);
                step();
            end
            @(negedge clk);
            check($sformatf("t4_rv_f%0d", f), 32'(b3.if_rvalid), 32'd1);
            case (f)
                0: begin
                    check("t4_data0", b3.if_rdata, 32'hDEAD_BEDF);
                    check("t4_gnt1",  32'(b3.if_gnt), 32'd1);
                    check("t4_addr1", b3.ram_addr,    32'h4);
                end
                1: begin
                    check("t4_data1", b3.if_rdata, 32'hDEAD_BEE3);
                    check("t4_gnt2",  32'(b3.if_gnt), 32'd1);
                    check("t4_addr2", b3.ram_addr,    32'h8);
                end
                default: begin
                    check("t4_data2",    b3.if_rdata,      32'hDEAD_BEE7);
                    check("t4_en_last",  32'(b3.ram_en),   32'd0);
                    check("t4_stall_dn", 32'(b3.stall_if), 32'd0);
                end
            endcase
            step();
            if (f == 0) b3.if_addr = 32'h8;
            if (f == 1) b3.if_req = 1'b0;
        end

        // Reset one cycle into a read aborts it
        b3.if_req = 1'b1; b3.if_addr = 32'hC;
        @(negedge clk);
        check("t5_gnt", 32'(b3.if_gnt), 32'd1);
        step();
        b3.if_req = 1'b0;
        reset = 1'b1;
        #1;
        check("t5_rst_rvalid", 32'(b3.if_rvalid), 32'd0);
        check("t5_rst_rdata",  b3.if_rdata,       32'h0);
        check("t5_rst_stall",  32'(b3.stall_if),  32'd0);
        check("t5_rst_en",     32'(b3.ram_en),    32'd0);
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t5_no_rv%0d", k), 32'(b3.if_rvalid), 32'd0);
            step();
        end
        b3.if_req = 1'b1; b3.if_addr = 32'h4;
        @(negedge clk);
        check("t5_regnt",      32'(b3.if_gnt), 32'd1);
        check("t5_regnt_addr", b3.ram_addr,    32'h4);
        step();
        b3.if_req = 1'b0;
        step();
        step();
        @(negedge clk);
        check("t5_re_rv",    32'(b3.if_rvalid), 32'd1);
        check("t5_re_rdata", b3.if_rdata,       32'hDEAD_BEE3);
        step();

        // MEM request withdrawn while IF owns the port
        b3.if_req = 1'b1; b3.if_addr = 32'h8;
        @(negedge clk);
        check("t6_if_gnt", 32'(b3.if_gnt), 32'd1);
        step();
        b3.if_req = 1'b0;
        b3.mem_req = 1'b1; b3.mem_we = 1'b0; b3.mem_addr_in = 32'h40;
        @(negedge clk);
        check("t6_mem_gnt1",   32'(b3.mem_gnt),   32'd0);
        check("t6_en1",        32'(b3.ram_en),    32'd0);
        check("t6_stall_mem1", 32'(b3.stall_mem), 32'd1);
        check("t6_stall_if1",  32'(b3.stall_if),  32'd1);
        step();
        b3.mem_req = 1'b0;
        @(negedge clk);
        check("t6_stall_mem2", 32'(b3.stall_mem), 32'd0);
        check("t6_mem_gnt2",   32'(b3.mem_gnt),   32'd0);
        step();
        @(negedge clk);
        check("t6_if_rv3",   32'(b3.if_rvalid), 32'd1);
        check("t6_if_data3", b3.if_rdata,       32'hDEAD_BEE7);
        check("t6_mem_gnt3", 32'(b3.mem_gnt),   32'd0);
        check("t6_en3",      32'(b3.ram_en),    32'd0);
        step();
        @(negedge clk);
        check("t6_mem_rv4", 32'(b3.mem_rvalid), 32'd0);
        check("t6_mem_rdata_hold", b3.mem_rdata_out, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
